// File: rtl/pipe_fwd_tracker.sv
// rtl/pipe_fwd_tracker.sv - in-flight write tracker with N-source forwarding, load-use stall and write-back
module pipe_fwd_tracker #(
    parameter int DSIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_wen,
    input  logic                  id_is_load,
    input  logic [RSIZE-1:0]      id_waddr,
    input  logic [NSRC*RSIZE-1:0] id_raddr,
    input  logic [NSRC*DSIZE-1:0] rf_rdata,
    input  logic                  flush,
    input  logic [DSIZE-1:0]      ex_data,
    input  logic [DSIZE-1:0]      mem_data,
    output logic [NSRC*DSIZE-1:0] opnd,
    output logic                  stall,
    output logic                  wb_en,
    output logic [RSIZE-1:0]      wb_addr,
    output logic [DSIZE-1:0]      wb_data,
    output logic [15:0]           stall_cnt
);

    // Slot 1 result lives on ex_data and load-ness only matters up to slot 2,
    // so data/ready start at slot 2 and the load flag stops there.
    logic [DEPTH:1]   s_valid;
    logic [DEPTH:1]   s_wen;
    logic [2:1]       s_load;
    logic [DEPTH:2]   s_ready;
    logic [RSIZE-1:0] s_waddr [1:DEPTH];
    logic [DSIZE-1:0] s_data  [2:DEPTH];
    logic [NSRC-1:0]  src_load_hit;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [RSIZE-1:0] ra;
        logic             is_zero;
        logic [DEPTH:1]   hit;
        logic [DSIZE-1:0] sel;

        assign ra      = id_raddr[i*RSIZE +: RSIZE];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);

        // A flushed slot-1 producer no longer exists, so it cannot be forwarded from.
        for (genvar k = 1; k <= DEPTH; k++) begin : g_slot
            assign hit[k] = s_valid[k] && s_wen[k] && (s_waddr[k] == ra) && !is_zero
                            && ((k == 1) ? !flush : 1'b1);
        end

        always_comb begin
            sel = rf_rdata[i*DSIZE +: DSIZE];
            for (int k = DEPTH; k >= 2; k--) begin
                if (hit[k]) begin
                    sel = (k == 2 && !s_ready[2]) ? mem_data : s_data[k];
                end
            end
            if (hit[1]) begin
                sel = ex_data;
            end
            if (is_zero) begin
                sel = '0;
            end
        end

        assign opnd[i*DSIZE +: DSIZE] = sel;
        assign src_load_hit[i]        = hit[1] && s_load[1];
    end

    assign stall = id_valid && (|src_load_hit) && !flush;

    assign wb_en   = s_valid[DEPTH] && s_wen[DEPTH] && s_ready[DEPTH]
                     && !((ZERO_REG != 0) && (s_waddr[DEPTH] == '0));
    assign wb_addr = s_waddr[DEPTH];
    assign wb_data = s_data[DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid   <= '0;
            s_wen     <= '0;
            s_load    <= '0;
            s_ready   <= '0;
            stall_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                s_waddr[k] <= '0;
            end
            for (int k = 2; k <= DEPTH; k++) begin
                s_data[k] <= '0;
            end
        end else begin
            s_valid[1] <= id_valid && !stall;
            s_wen[1]   <= id_wen;
            s_load[1]  <= id_is_load;
            s_waddr[1] <= id_waddr;

            s_valid[2] <= s_valid[1] && !flush;
            s_wen[2]   <= s_wen[1];
            s_load[2]  <= s_load[1];
            s_waddr[2] <= s_waddr[1];
            s_ready[2] <= !s_load[1];
            s_data[2]  <= ex_data;

            // Loads pick up their memory data on the way into slot 3.
            s_valid[3] <= s_valid[2];
            s_wen[3]   <= s_wen[2];
            s_waddr[3] <= s_waddr[2];
            s_ready[3] <= s_ready[2] || s_load[2];
            s_data[3]  <= s_load[2] ? mem_data : s_data[2];

            for (int k = 4; k <= DEPTH; k++) begin
                s_valid[k] <= s_valid[k-1];
                s_wen[k]   <= s_wen[k-1];
                s_waddr[k] <= s_waddr[k-1];
                s_ready[k] <= s_ready[k-1];
                s_data[k]  <= s_data[k-1];
            end

            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule
